fifo_flags: RTL

- Parametrised synchronous first-word-fall-through FIFO.
- Generalises the existing 8-bit byte fifo with configurable data width and depth.
- Adds almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and a high-water-mark counter.
- Buffers data between the SPI capture path and slower consumers such as the UART/USB drain logic.

---
 rtl/fifo_flags.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_flags.sv
// Parametrised synchronous first-word-fall-through FIFO with threshold flags,
// synchronous flush, sticky overflow/underflow errors and a high-water mark.
module fifo_flags #(
    parameter int WIDTH         = 8,
    parameter int NUM           = 256,
    parameter int AFULL_MARGIN  = 4,
    parameter int AEMPTY_MARGIN = 4,
    localparam int AW           = $clog2(NUM),
    localparam int CW           = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_strobe,
    output logic             space_available,
    output logic [WIDTH-1:0] read_data,
    input  logic             read_strobe,
    output logic             data_available,
    input  logic             flush,
    input  logic             clear_errors,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CW-1:0]    high_water,
    output logic [AW-1:0]    write_ptr,
    output logic [AW-1:0]    read_ptr,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM);
    localparam logic [CW-1:0] AFULL_TH  = CW'(NUM - AFULL_MARGIN);
    localparam logic [CW-1:0] AEMPTY_TH = CW'(AEMPTY_MARGIN);

    logic [WIDTH-1:0] mem [NUM];

    logic          wr_ok;
    logic          rd_ok;
    logic          ov_event;
    logic          uf_event;
    logic [CW-1:0] count_next;

    // Status flags come from registered occupancy only, so they move in step with count.
    assign space_available = (count < FULL_CNT);
    assign data_available  = (count != '0);
    assign almost_full     = (count >= AFULL_TH);
    assign almost_empty    = (count <= AEMPTY_TH);

    assign read_data = mem[read_ptr];

    always_comb begin
        wr_ok      = 1'b0;
        rd_ok      = 1'b0;
        ov_event   = 1'b0;
        uf_event   = 1'b0;
        count_next = '0;
        // Flush discards same-cycle strobes entirely, including their error side effects.
        if (!flush) begin
            wr_ok      = write_strobe & space_available;
            rd_ok      = read_strobe & data_available;
            ov_event   = write_strobe & ~space_available;
            uf_event   = read_strobe & ~data_available;
            count_next = count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr  <= '0;
            read_ptr   <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            high_water <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                write_ptr <= '0;
                read_ptr  <= '0;
            end else begin
                if (wr_ok)
                    write_ptr <= write_ptr + AW'(1);
                if (rd_ok)
                    read_ptr <= read_ptr + AW'(1);
            end

            // A new error event in the same cycle as clear_errors leaves the flag set.
            overflow  <= ov_event | (overflow & ~clear_errors);
            underflow <= uf_event | (underflow & ~clear_errors);

            if (clear_errors)
                high_water <= count;
            else if (count_next > high_water)
                high_water <= count_next;
        end
    end

    // Storage carries no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok)
            mem[write_ptr] <= write_data;
    end

endmodule
